// File: rtl/l1i_mau_if.sv
// L1I refill unit bus bundle: cache-side line request/ack and memory-side beat
// request/response. The slave modport is the refill unit's view.
interface l1i_mau_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 256
);
  logic                  mau_req_val;
  logic [ADDR_WIDTH-1:0] mau_req_addr;
  logic                  mau_req_ack;
  logic [LINE_SIZE-1:0]  mau_ack_data;

  logic                  mem_req_val;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ack;
  logic                  mem_rsp_val;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  // Environment side: the L1I cache plus the memory bus.
  modport master (
    output mau_req_val, mau_req_addr, mem_req_ack, mem_rsp_val, mem_rsp_data,
    input  mau_req_ack, mau_ack_data, mem_req_val, mem_req_addr
  );

  modport slave (
    input  mau_req_val, mau_req_addr, mem_req_ack, mem_rsp_val, mem_rsp_data,
    output mau_req_ack, mau_ack_data, mem_req_val, mem_req_addr
  );
endinterface

// File: rtl/l1i_mau.sv
// L1I refill unit: splits a line fill into DATA_WIDTH beat reads and returns the
// assembled line. Optional last-line reuse is enabled by L1I_MAU_LINE_BUF_EN.
module l1i_mau #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 256
) (
  input  logic         clk,
  input  logic         rst,
  l1i_mau_if.slave     bus
);

  localparam int BEATS   = LINE_SIZE / DATA_WIDTH;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int CNT_W   = BEAT_W + 1;
  localparam int OFF_W   = $clog2(LINE_SIZE / 8);
  localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);

  localparam logic [CNT_W-1:0]      BEATS_C  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0]      LAST_C   = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] base_q,    base_d;
  logic [CNT_W-1:0]      req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]      rsp_cnt_q, rsp_cnt_d;
  logic [LINE_SIZE-1:0]  line_q,    line_d;

  logic                  req_pending;
  logic                  req_fire;
  logic [CNT_W-1:0]      req_issued;
  logic                  rsp_fire;
  logic                  rsp_last;
  logic [ADDR_WIDTH-1:0] req_line_addr;
  logic                  hit;

  assign req_line_addr = bus.mau_req_addr & ~OFF_MASK;

  assign req_pending = (state_q == ST_BUSY) && (req_cnt_q < BEATS_C);
  assign req_fire    = req_pending && bus.mem_req_ack;
  // A beat accepted this very cycle may already have its response on the bus.
  assign req_issued  = req_cnt_q + CNT_W'(req_fire);
  assign rsp_fire    = (state_q == ST_BUSY) && bus.mem_rsp_val && (rsp_cnt_q < req_issued);
  assign rsp_last    = rsp_fire && (rsp_cnt_q == LAST_C);

`ifdef L1I_MAU_LINE_BUF_EN
  logic valid_q, valid_d;
  assign hit = valid_q && (req_line_addr == base_q);
`else
  assign hit = 1'b0;
`endif

  assign bus.mem_req_val  = req_pending;
  assign bus.mem_req_addr = req_pending ? base_q + (ADDR_WIDTH'(req_cnt_q) << BYTE_SH) : '0;
  assign bus.mau_req_ack  = (state_q == ST_ACK);
  assign bus.mau_ack_data = line_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
`ifdef L1I_MAU_LINE_BUF_EN
    valid_d   = valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.mau_req_val) begin
          if (hit) begin
            state_d = ST_ACK;
          end else begin
            state_d   = ST_BUSY;
            base_d    = req_line_addr;
            req_cnt_d = '0;
            rsp_cnt_d = '0;
`ifdef L1I_MAU_LINE_BUF_EN
            // Buffer contents are about to be overwritten beat by beat.
            valid_d   = 1'b0;
`endif
          end
        end
      end
      ST_BUSY: begin
        if (req_fire) req_cnt_d = req_cnt_q + 1'b1;
        if (rsp_fire) rsp_cnt_d = rsp_cnt_q + 1'b1;
        if (rsp_last) begin
          state_d = ST_ACK;
`ifdef L1I_MAU_LINE_BUF_EN
          valid_d = 1'b1;
`endif
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line_d = line_q;
    for (int k = 0; k < BEATS; k++) begin
      if (rsp_fire && (rsp_cnt_q[BEAT_W-1:0] == BEAT_W'(k))) begin
        line_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      state_q   <= ST_IDLE;
      base_q    <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      // NOTE: the line buffer is reset, unlike a typical RAM, because it drives mau_ack_data directly.
      line_q    <= '0;
`ifdef L1I_MAU_LINE_BUF_EN
      valid_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      line_q    <= line_d;
`ifdef L1I_MAU_LINE_BUF_EN
      valid_q   <= valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_l1i_mau.sv
// Directed bench for l1i_mau: single/unaligned fills, backpressure, mid-fill reset,
// spurious responses and (with L1I_MAU_LINE_BUF_EN) last-line reuse.
module tb_l1i_mau;

  logic clk;
  logic rst;

  l1i_mau_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(256)) bus ();

  l1i_mau #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] xr;
  } rsp_t;

  rsp_t        mq[$];
  logic [31:0] issued[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          tick     = 0;
  int          rsp_delay  = 1;
  int          stall_beat = -1;
  int          stall_left = 0;
  int          acc_cnt    = 0;
  logic [31:0] data_xor   = 32'h0;
  logic        spur       = 1'b0;

  // Memory model: accepts beats, returns beat address ^ data_xor rsp_delay cycles later.
  initial begin : mem_model
    logic        acc;
    logic [31:0] a;
    bus.mem_req_ack  = 1'b1;
    bus.mem_rsp_val  = 1'b0;
    bus.mem_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      acc = bus.mem_req_val && bus.mem_req_ack;
      a   = bus.mem_req_addr;
      @(posedge clk);
      #1;
      tick++;
      if (acc) begin
        mq.push_back('{tick + rsp_delay - 1, a, data_xor});
        acc_cnt++;
      end
      if (spur) begin
        bus.mem_rsp_val  = 1'b1;
        bus.mem_rsp_data = 32'hDEAD_BEEF;
      end else if (mq.size() > 0 && mq[0].due <= tick) begin
        bus.mem_rsp_val  = 1'b1;
        bus.mem_rsp_data = mq[0].addr ^ mq[0].xr;
        void'(mq.pop_front());
      end else begin
        bus.mem_rsp_val  = 1'b0;
        bus.mem_rsp_data = 32'h0;
      end
      if (acc_cnt == stall_beat && stall_left > 0) begin
        bus.mem_req_ack = 1'b0;
        stall_left--;
      end else begin
        bus.mem_req_ack = 1'b1;
      end
    end
  end

  function automatic logic [255:0] exp_line(input logic [31:0] base, input logic [31:0] xr);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = (base + 32'(4 * k)) ^ xr;
    return r;
  endfunction

  // Cycle k counts from the edge that samples the request (cycle 1 follows it).
  task automatic run_fill(input logic [31:0] addr, input logic [31:0] xr, input int dly,
                          input int sbeat, input int slen,
                          output int ack_cyc, output int ack_cnt, output int req_cyc,
                          output logic [255:0] line, output logic stable);
    issued.delete();
    @(posedge clk);
    #2;
    data_xor = xr; rsp_delay = dly; stall_beat = sbeat; stall_left = slen; acc_cnt = 0;
    bus.mau_req_addr = addr;
    bus.mau_req_val  = 1'b1;
    ack_cyc = -1; ack_cnt = 0; req_cyc = 0; line = '0; stable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #2;
      if (ack_cyc > 0) bus.mau_req_val = 1'b0;
      @(negedge clk);
      if (bus.mem_req_val) req_cyc++;
      if (bus.mem_req_val && bus.mem_req_ack) issued.push_back(bus.mem_req_addr);
      if (bus.mau_req_ack) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = k;
          line    = bus.mau_ack_data;
        end
      end else if (ack_cyc > 0 && bus.mau_ack_data !== line) begin
        stable = 1'b0;
      end
      if (ack_cyc > 0 && k >= ack_cyc + 3) break;
    end
    bus.mau_req_val = 1'b0;
    n_checks++;
    if (ack_cyc < 0) begin
      n_fail++;
      $display("FAIL fill_timeout addr=%h: no mau_req_ack within 60 cycles", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mau_req_val  = 1'b0;
    bus.mau_req_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.mau_req_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", bus.mau_req_ack); end
    n_checks++; if (bus.mau_ack_data !== 256'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.mau_ack_data); end
    n_checks++; if (bus.mem_req_val !== 1'b0) begin n_fail++; $display("FAIL reset_mem_val got %b exp 0", bus.mem_req_val); end
    n_checks++; if (bus.mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_req_addr); end
    rst = 1'b0;
  endtask

  task automatic test_single_fill();
    int ac, an, rc; logic [255:0] ln; logic st;
    run_fill(32'h0000_1040, 32'h0, 1, -1, 0, ac, an, rc, ln, st);
    n_checks++; if (issued.size() != 8) begin n_fail++; $display("FAIL single_nbeats got %0d exp 8", issued.size()); end
    for (int k = 0; k < 8 && k < issued.size(); k++) begin
      n_checks++;
      if (issued[k] !== 32'h1040 + 32'(4 * k)) begin
        n_fail++; $display("FAIL single_addr[%0d] got %h exp %h", k, issued[k], 32'h1040 + 32'(4 * k));
      end
    end
    n_checks++; if (ac != 10) begin n_fail++; $display("FAIL single_ack_cycle got %0d exp 10", ac); end
    n_checks++; if (an != 1) begin n_fail++; $display("FAIL single_ack_count got %0d exp 1", an); end
    n_checks++; if (rc != 8) begin n_fail++; $display("FAIL single_req_cycles got %0d exp 8", rc); end
    n_checks++; if (ln[31:0] !== 32'h1040) begin n_fail++; $display("FAIL single_beat0 got %h exp 00001040", ln[31:0]); end
    n_checks++; if (ln[255:224] !== 32'h105C) begin n_fail++; $display("FAIL single_beat7 got %h exp 0000105c", ln[255:224]); end
    n_checks++; if (ln !== exp_line(32'h1040, 32'h0)) begin n_fail++; $display("FAIL single_line got %h exp %h", ln, exp_line(32'h1040, 32'h0)); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL single_stable got %b exp 1", st); end
  endtask

  task automatic test_unaligned();
    int ac, an, rc; logic [255:0] ln_u, ln_a; logic st;
    run_fill(32'h0000_2013, 32'h0, 1, -1, 0, ac, an, rc, ln_u, st);
    n_checks++;
    if (issued.size() == 0 || issued[0] !== 32'h2000) begin
      n_fail++; $display("FAIL unaligned_first_addr got %h exp 00002000", issued.size() ? issued[0] : 32'hx);
    end
    n_checks++; if (ln_u !== exp_line(32'h2000, 32'h0)) begin n_fail++; $display("FAIL unaligned_line got %h exp %h", ln_u, exp_line(32'h2000, 32'h0)); end
    run_fill(32'h0000_2000, 32'h0, 1, -1, 0, ac, an, rc, ln_a, st);
    n_checks++; if (ln_a !== exp_line(32'h2000, 32'h0)) begin n_fail++; $display("FAIL aligned_line got %h exp %h", ln_a, exp_line(32'h2000, 32'h0)); end
  endtask

  task automatic test_backpressure();
    int ac, an, rc; logic [255:0] ln; logic st;
    run_fill(32'h0000_4000, 32'h0, 4, 2, 3, ac, an, rc, ln, st);
    n_checks++; if (issued.size() != 8) begin n_fail++; $display("FAIL bp_nbeats got %0d exp 8", issued.size()); end
    for (int k = 0; k < 8 && k < issued.size(); k++) begin
      n_checks++;
      if (issued[k] !== 32'h4000 + 32'(4 * k)) begin
        n_fail++; $display("FAIL bp_addr[%0d] got %h exp %h", k, issued[k], 32'h4000 + 32'(4 * k));
      end
    end
    n_checks++; if (ac != 16) begin n_fail++; $display("FAIL bp_ack_cycle got %0d exp 16", ac); end
    n_checks++; if (an != 1) begin n_fail++; $display("FAIL bp_ack_count got %0d exp 1", an); end
    n_checks++; if (rc != 11) begin n_fail++; $display("FAIL bp_req_cycles got %0d exp 11", rc); end
    n_checks++; if (ln !== exp_line(32'h4000, 32'h0)) begin n_fail++; $display("FAIL bp_line got %h exp %h", ln, exp_line(32'h4000, 32'h0)); end
  endtask

  task automatic test_reset_mid_fill();
    int ac, an, rc; logic [255:0] ln; logic st;
    @(posedge clk);
    #2;
    data_xor = 32'hA5A5_0000; rsp_delay = 1; stall_beat = -1; stall_left = 0; acc_cnt = 0;
    bus.mau_req_addr = 32'h0000_1000;
    bus.mau_req_val  = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    bus.mau_req_val = 1'b0;
    mq.delete();
    bus.mem_rsp_val = 1'b0;
    #1;
    n_checks++; if (bus.mau_req_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack got %b exp 0", bus.mau_req_ack); end
    n_checks++; if (bus.mau_ack_data !== 256'h0) begin n_fail++; $display("FAIL midrst_data got %h exp 0", bus.mau_ack_data); end
    n_checks++; if (bus.mem_req_val !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_val got %b exp 0", bus.mem_req_val); end
    n_checks++; if (bus.mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_mem_addr got %h exp 0", bus.mem_req_addr); end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    run_fill(32'h0000_3000, 32'h0, 1, -1, 0, ac, an, rc, ln, st);
    n_checks++; if (ac != 10) begin n_fail++; $display("FAIL midrst_ack_cycle got %0d exp 10", ac); end
    n_checks++; if (ln !== exp_line(32'h3000, 32'h0)) begin n_fail++; $display("FAIL midrst_line got %h exp %h", ln, exp_line(32'h3000, 32'h0)); end
  endtask

  task automatic test_spurious_rsp();
    int ac, an, rc; logic [255:0] ln; logic st;
    @(posedge clk);
    #2;
    spur = 1'b1;
    bus.mem_rsp_val  = 1'b1;
    bus.mem_rsp_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (bus.mau_req_ack !== 1'b0) begin n_fail++; $display("FAIL spur_ack[%0d] got %b exp 0", k, bus.mau_req_ack); end
      n_checks++; if (bus.mem_req_val !== 1'b0) begin n_fail++; $display("FAIL spur_mem_val[%0d] got %b exp 0", k, bus.mem_req_val); end
      n_checks++;
      if (bus.mau_ack_data !== exp_line(32'h3000, 32'h0)) begin
        n_fail++; $display("FAIL spur_data[%0d] got %h exp %h", k, bus.mau_ack_data, exp_line(32'h3000, 32'h0));
      end
    end
    @(posedge clk);
    #2;
    spur = 1'b0;
    bus.mem_rsp_val = 1'b0;
    run_fill(32'h0000_5000, 32'h0, 1, -1, 0, ac, an, rc, ln, st);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (ln[k*32 +: 32] === 32'hDEAD_BEEF) begin n_fail++; $display("FAIL spur_leak beat %0d got deadbeef exp %h", k, 32'h5000 + 32'(4 * k)); end
    end
    n_checks++; if (ln !== exp_line(32'h5000, 32'h0)) begin n_fail++; $display("FAIL spur_line got %h exp %h", ln, exp_line(32'h5000, 32'h0)); end
  endtask

  task automatic test_line_buf();
    int ac, an, rc; logic [255:0] ln; logic st;
    run_fill(32'h0000_1040, 32'h0, 1, -1, 0, ac, an, rc, ln, st);
    n_checks++; if (ac != 10) begin n_fail++; $display("FAIL lb_first_ack_cycle got %0d exp 10", ac); end
    run_fill(32'h0000_1040, 32'h0, 1, -1, 0, ac, an, rc, ln, st);
`ifdef L1I_MAU_LINE_BUF_EN
    n_checks++; if (ac != 1) begin n_fail++; $display("FAIL lb_hit_ack_cycle got %0d exp 1", ac); end
    n_checks++; if (rc != 0) begin n_fail++; $display("FAIL lb_hit_req_cycles got %0d exp 0", rc); end
`else
    n_checks++; if (ac != 10) begin n_fail++; $display("FAIL lb_repeat_ack_cycle got %0d exp 10", ac); end
    n_checks++; if (rc != 8) begin n_fail++; $display("FAIL lb_repeat_req_cycles got %0d exp 8", rc); end
`endif
    n_checks++; if (an != 1) begin n_fail++; $display("FAIL lb_repeat_ack_count got %0d exp 1", an); end
    n_checks++; if (ln !== exp_line(32'h1040, 32'h0)) begin n_fail++; $display("FAIL lb_repeat_line got %h exp %h", ln, exp_line(32'h1040, 32'h0)); end
    run_fill(32'h0000_1080, 32'h0, 1, -1, 0, ac, an, rc, ln, st);
    n_checks++; if (ac != 10) begin n_fail++; $display("FAIL lb_miss_ack_cycle got %0d exp 10", ac); end
    n_checks++; if (rc != 8) begin n_fail++; $display("FAIL lb_miss_req_cycles got %0d exp 8", rc); end
    n_checks++; if (ln !== exp_line(32'h1080, 32'h0)) begin n_fail++; $display("FAIL lb_miss_line got %h exp %h", ln, exp_line(32'h1080, 32'h0)); end
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_unaligned();
    test_backpressure();
    test_reset_mid_fill();
    test_spurious_rsp();
    test_line_buf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
